// File: rtl/player_sprite_renderer.sv
// Player sprite renderer: 4-stage pixel pipeline that hit-tests the beam against the latched
// sprite box, fetches from the sprite selector and keys out KEY_COLOR. Optional macro: SPRITE_HFLIP_EN.
module player_sprite_renderer #(
    parameter int          SPRITE_W  = 128,
    parameter int          SPRITE_H  = 128,
    parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        video_on,
    input  logic        frame_start,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
`ifdef SPRITE_HFLIP_EN
    input  logic        facing_left,
`endif
    output logic [13:0] sprite_addr,
    input  logic [11:0] sprite_pixel,
    output logic        pixel_valid,
    output logic [11:0] pixel_rgb
);

    localparam int              COL_W   = $clog2(SPRITE_W);
    localparam int              ROW_W   = $clog2(SPRITE_H);
    localparam logic [10:0]     W11     = 11'(SPRITE_W);
    localparam logic [10:0]     H11     = 11'(SPRITE_H);
    localparam logic [9:0]      H_LIMIT = 10'd640;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPRITE_W - 1);

    logic [9:0]       lat_x;
    logic [9:0]       lat_y;
    logic [10:0]      x_end;
    logic [10:0]      y_end;
    logic             in_x;
    logic             in_y;
    logic             hit;
    logic [COL_W-1:0] dx;
    logic [ROW_W-1:0] dy;
    logic [COL_W-1:0] col;
    logic [13:0]      addr_next;
    logic             hit_s1;
    logic             hit_s2;
    logic             hit_s3;
    logic             opaque;

`ifdef SPRITE_HFLIP_EN
    logic             lat_flip;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lat_flip <= 1'b0;
        end else if (frame_start) begin
            lat_flip <= facing_left;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lat_x <= '0;
            lat_y <= '0;
        end else if (frame_start) begin
            lat_x <= pos_x;
            lat_y <= pos_y;
        end
    end

    // Box edges are summed at 11 bits so a sprite hanging past column 1023 cannot wrap to 0.
    always_comb begin
        x_end = {1'b0, lat_x} + W11;
        y_end = {1'b0, lat_y} + H11;
        in_x  = ({1'b0, hcount} >= {1'b0, lat_x}) && ({1'b0, hcount} < x_end)
                && (lat_x < H_LIMIT);
        in_y  = ({1'b0, vcount} >= {1'b0, lat_y}) && ({1'b0, vcount} < y_end);
        hit   = video_on && in_x && in_y;
    end

    // Only the low bits of the offsets matter: on a hit they are already below the sprite size.
    always_comb begin
        dx  = hcount[COL_W-1:0] - lat_x[COL_W-1:0];
        dy  = vcount[ROW_W-1:0] - lat_y[ROW_W-1:0];
        col = dx;
`ifdef SPRITE_HFLIP_EN
        if (lat_flip) begin
            col = COL_MAX - dx;
        end
`endif
        addr_next = '0;
        if (hit) begin
            addr_next = 14'({dy, col});
        end
    end

    // Sprite selector contract: fixed 2-cycle read latency, no backpressure; sprite_pixel
    // belongs to the address presented two clocks earlier, so hit_s3 lines up with it.
    always_comb begin
        opaque = hit_s3 && (sprite_pixel != KEY_COLOR);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sprite_addr <= '0;
            hit_s1      <= 1'b0;
            hit_s2      <= 1'b0;
            hit_s3      <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_rgb   <= '0;
        end else begin
            sprite_addr <= addr_next;
            hit_s1      <= hit;
            hit_s2      <= hit_s1;
            hit_s3      <= hit_s2;
            pixel_valid <= opaque;
            pixel_rgb   <= opaque ? sprite_pixel : 12'h000;
        end
    end

endmodule

// File: tb/tb_player_sprite_renderer.sv
// Directed bench for player_sprite_renderer with a 2-cycle sprite ROM model.
// Define SPRITE_HFLIP_EN to build and exercise the mirrored variant.
module tb_player_sprite_renderer;

    logic        clk = 1'b0;
    logic        rst_l = 1'b1;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = '0;
    logic        video_on = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic [13:0] sprite_addr;
    logic [11:0] sprite_pixel = '0;
    logic        pixel_valid;
    logic [11:0] pixel_rgb;
`ifdef SPRITE_HFLIP_EN
    logic        facing_left = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    logic [12:0] exp_q[$];
    logic [11:0] rom_d1 = '0;

    player_sprite_renderer dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .hcount       (hcount),
        .vcount       (vcount),
        .video_on     (video_on),
        .frame_start  (frame_start),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
`ifdef SPRITE_HFLIP_EN
        .facing_left  (facing_left),
`endif
        .sprite_addr  (sprite_addr),
        .sprite_pixel (sprite_pixel),
        .pixel_valid  (pixel_valid),
        .pixel_rgb    (pixel_rgb)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Sprite selector model: two-register read path, content is addr ^ 5A5 plus two keyed entries.
    function automatic logic [11:0] rom(input logic [13:0] a);
        if (a == 14'h0082) return 12'hF0F;
        if (a == 14'h0083) return 12'h0A5;
        return a[11:0] ^ 12'h5A5;
    endfunction

    always @(posedge clk) begin
        rom_d1       <= rom(sprite_addr);
        sprite_pixel <= rom_d1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload_empty();
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(13'h0000);
    endtask

    // One pixel per call: drives at the falling edge, checks stage-1 address for this
    // pixel and the output for the pixel driven three calls earlier.
    task automatic cyc(input logic [9:0] h, input logic [9:0] v, input logic on, input logic fs,
                       input logic [13:0] ea, input logic ev, input logic [11:0] er);
        logic [12:0] e;
        hcount      = h;
        vcount      = v;
        video_on    = on;
        frame_start = fs;
        exp_q.push_back({ev, er});
        @(negedge clk);
        frame_start = 1'b0;
        chk("sprite_addr", 16'(sprite_addr), 16'(ea));
        if (exp_q.size() == 4) begin
            e = exp_q.pop_front();
            chk("pixel_valid", 16'(pixel_valid), 16'(e[12]));
            chk("pixel_rgb", 16'(pixel_rgb), 16'(e[11:0]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(10'd0, 10'd0, 1'b0, 1'b0, 14'h0000, 1'b0, 12'h000);
    endtask

    initial begin
        logic [13:0] a;
        logic        in_box;

        // reset state, asserted before any clock edge
        #1 rst_l = 1'b0;
        #1;
        chk("reset_addr", 16'(sprite_addr), 16'h0000);
        chk("reset_valid", 16'(pixel_valid), 16'h0000);
        chk("reset_rgb", 16'(pixel_rgb), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        preload_empty();

        // latch (100,200); corners of the box
        pos_x = 10'd100; pos_y = 10'd200;
        cyc(10'd0,   10'd0,   1'b0, 1'b1, 14'h0000, 1'b0, 12'h000);
        cyc(10'd100, 10'd200, 1'b1, 1'b0, 14'h0000, 1'b1, 12'h5A5);
        cyc(10'd227, 10'd327, 1'b1, 1'b0, 14'h3FFF, 1'b1, 12'hA5A);
        cyc(10'd99,  10'd250, 1'b1, 1'b0, 14'h0000, 1'b0, 12'h000);
        cyc(10'd228, 10'd250, 1'b1, 1'b0, 14'h0000, 1'b0, 12'h000);
        cyc(10'd150, 10'd327, 1'b1, 1'b0, 14'h3FB2, 1'b1, 12'hA17);
        cyc(10'd150, 10'd328, 1'b1, 1'b0, 14'h0000, 1'b0, 12'h000);
        cyc(10'd150, 10'd199, 1'b1, 1'b0, 14'h0000, 1'b0, 12'h000);
        cyc(10'd150, 10'd250, 1'b0, 1'b0, 14'h0000, 1'b0, 12'h000);

        // key colour versus opaque pixel
        cyc(10'd102, 10'd201, 1'b1, 1'b0, 14'h0082, 1'b0, 12'h000);
        cyc(10'd103, 10'd201, 1'b1, 1'b0, 14'h0083, 1'b1, 12'h0A5);

        // mid-frame relatch: old box still applies on the frame_start cycle
        pos_x = 10'd300; pos_y = 10'd200;
        cyc(10'd101, 10'd200, 1'b1, 1'b1, 14'h0001, 1'b1, 12'h5A4);
        cyc(10'd101, 10'd200, 1'b1, 1'b0, 14'h0000, 1'b0, 12'h000);
        cyc(10'd300, 10'd200, 1'b1, 1'b0, 14'h0000, 1'b1, 12'h5A5);

        // video_on toggling inside the sprite keeps pixel order
        cyc(10'd301, 10'd205, 1'b1, 1'b0, 14'h0281, 1'b1, 12'h724);
        cyc(10'd302, 10'd205, 1'b0, 1'b0, 14'h0000, 1'b0, 12'h000);
        cyc(10'd303, 10'd205, 1'b1, 1'b0, 14'h0283, 1'b1, 12'h726);
        cyc(10'd304, 10'd205, 1'b0, 1'b0, 14'h0000, 1'b0, 12'h000);
        cyc(10'd305, 10'd205, 1'b1, 1'b0, 14'h0285, 1'b1, 12'h720);

        // right-edge clipping: pos_x=600, full line sweep, then wrap of hcount
        pos_x = 10'd600; pos_y = 10'd0;
        cyc(10'd0, 10'd0, 1'b0, 1'b1, 14'h0000, 1'b0, 12'h000);
        for (int h = 0; h < 650; h++) begin
            in_box = (h >= 600) && (h < 640);
            a = in_box ? 14'(14'h0500 + 14'(h - 600)) : 14'h0000;
            cyc(10'(h), 10'd10, 1'(h < 640), 1'b0, a, in_box, in_box ? (a[11:0] ^ 12'h5A5) : 12'h000);
        end
        for (int h = 0; h < 8; h++) cyc(10'(h), 10'd11, 1'b1, 1'b0, 14'h0000, 1'b0, 12'h000);

        // off-screen columns never hit, including a box whose 10-bit end would wrap
        pos_x = 10'd700; pos_y = 10'd0;
        cyc(10'd0,   10'd0, 1'b0, 1'b1, 14'h0000, 1'b0, 12'h000);
        cyc(10'd700, 10'd5, 1'b1, 1'b0, 14'h0000, 1'b0, 12'h000);
        cyc(10'd5,   10'd5, 1'b1, 1'b0, 14'h0000, 1'b0, 12'h000);
        pos_x = 10'd1000;
        cyc(10'd0,   10'd0, 1'b0, 1'b1, 14'h0000, 1'b0, 12'h000);
        cyc(10'd5,   10'd5, 1'b1, 1'b0, 14'h0000, 1'b0, 12'h000);

        // bottom clipping: pos_y=400, last visible row hits
        pos_x = 10'd10; pos_y = 10'd400;
        cyc(10'd0,  10'd0,   1'b0, 1'b1, 14'h0000, 1'b0, 12'h000);
        cyc(10'd12, 10'd479, 1'b1, 1'b0, 14'h2782, 1'b1, 12'h227);
        cyc(10'd12, 10'd480, 1'b0, 1'b0, 14'h0000, 1'b0, 12'h000);

`ifdef SPRITE_HFLIP_EN
        facing_left = 1'b1; pos_x = 10'd0; pos_y = 10'd0;
        cyc(10'd0, 10'd0, 1'b0, 1'b1, 14'h0000, 1'b0, 12'h000);
        cyc(10'd0, 10'd0, 1'b1, 1'b0, 14'h007F, 1'b1, 12'h5DA);
        cyc(10'd5, 10'd1, 1'b1, 1'b0, 14'h00FA, 1'b1, 12'h55F);
        facing_left = 1'b0;
        cyc(10'd0, 10'd0, 1'b0, 1'b1, 14'h0000, 1'b0, 12'h000);
        cyc(10'd5, 10'd1, 1'b1, 1'b0, 14'h0085, 1'b1, 12'h520);
`endif

        // asynchronous reset mid-sprite, then refill
        pos_x = 10'd100; pos_y = 10'd200;
        cyc(10'd0,   10'd0,   1'b0, 1'b1, 14'h0000, 1'b0, 12'h000);
        cyc(10'd110, 10'd210, 1'b1, 1'b0, 14'h050A, 1'b1, 12'h0AF);
        cyc(10'd111, 10'd210, 1'b1, 1'b0, 14'h050B, 1'b1, 12'h0AE);
        cyc(10'd112, 10'd210, 1'b1, 1'b0, 14'h050C, 1'b1, 12'h0A9);
        cyc(10'd113, 10'd210, 1'b1, 1'b0, 14'h050D, 1'b1, 12'h0A8);
        #2 rst_l = 1'b0;
        #1;
        chk("midreset_addr", 16'(sprite_addr), 16'h0000);
        chk("midreset_valid", 16'(pixel_valid), 16'h0000);
        chk("midreset_rgb", 16'(pixel_rgb), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        preload_empty();
        // latched box is back at (0,0) until the next frame_start
        cyc(10'd5,   10'd5,   1'b1, 1'b0, 14'h0285, 1'b1, 12'h720);
        cyc(10'd0,   10'd0,   1'b0, 1'b1, 14'h0000, 1'b0, 12'h000);
        cyc(10'd120, 10'd220, 1'b1, 1'b0, 14'h0A14, 1'b1, 12'hFB1);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
